// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among N requesters.
// One operation is issued per cycle and the result is registered with the owner's ID.
module alu_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N-1:0]      req_valid,
  input  logic [4*N-1:0]    req_op,
  input  logic [32*N-1:0]   req_v1,
  input  logic [32*N-1:0]   req_v2,
  output logic [N-1:0]      req_ready,
  output logic              resp_valid,
  output logic [ID_W-1:0]   resp_id,
  output logic [31:0]       resp_data,
  input  logic              resp_ready
);

  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] v1,
                                         input logic [31:0] v2);
    logic signed [31:0] s1;
    logic signed [31:0] s2;
    s1 = v1;
    s2 = v2;
    case (op)
      4'b1100:         alu_fn = v1 + v2;
      4'b1110:         alu_fn = v1 - v2;
      4'b1000:         alu_fn = v1 & v2;
      4'b1001:         alu_fn = v1 | v2;
      4'b1010:         alu_fn = v1 ^ v2;
      4'b1011:         alu_fn = ~(v1 | v2);
      4'b0110:         alu_fn = (s1 < s2) ? 32'd1 : 32'd0;
      4'b0000, 4'b0001: alu_fn = v2 << v1[4:0];
      4'b0010:         alu_fn = v2 >> v1[4:0];
      4'b0011:         alu_fn = 32'(s2 >>> v1[4:0]);
      4'b1111:         alu_fn = v2;
      default:         alu_fn = 32'd0;
    endcase
  endfunction

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_p0;
  logic            any_vld_p0;
  logic            issue_p0;
  logic [3:0]      op_p0;
  logic [31:0]     v1_p0;
  logic [31:0]     v2_p0;
  logic [31:0]     alu_p0;
  int              idx;

  // Stage p0: cyclic scan from rr_ptr, grant, and ALU operand mux
  always_comb begin
    any_vld_p0 = 1'b0;
    grant_p0   = '0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_vld_p0 && req_valid[idx]) begin
        any_vld_p0 = 1'b1;
        grant_p0   = ID_W'(idx);
      end
    end
  end

  assign issue_p0 = resetn && (!resp_valid || resp_ready) && any_vld_p0;

  always_comb begin
    req_ready = '0;
    if (issue_p0) req_ready[grant_p0] = 1'b1;
  end

  assign op_p0  = req_op[int'(grant_p0)*4 +: 4];
  assign v1_p0  = req_v1[int'(grant_p0)*32 +: 32];
  assign v2_p0  = req_v2[int'(grant_p0)*32 +: 32];
  assign alu_p0 = alu_fn(op_p0, v1_p0, v2_p0);

  // Stage p1: result register; a new issue overwrites, a lone drain only clears valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      rr_ptr     <= '0;
    end else if (issue_p0) begin
      resp_valid <= 1'b1;
      resp_id    <= grant_p0;
      resp_data  <= alu_p0;
      rr_ptr     <= (grant_p0 == ID_W'(N-1)) ? '0 : grant_p0 + 1'b1;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbiter and ALU.
module tb_alu_rr_arbiter;
  localparam int N = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req_valid;
  logic [4*N-1:0]  req_op;
  logic [32*N-1:0] req_v1;
  logic [32*N-1:0] req_v2;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [ID_W-1:0] resp_id;
  logic [31:0]     resp_data;
  logic            resp_ready;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model state
  bit          m_valid;
  int          m_id;
  logic [31:0] m_data;
  int          m_ptr;

  alu_rr_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_v1(req_v1), .req_v2(req_v2), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(a[4:0]);
    case (op)
      4'b1100: return a + b;
      4'b1110: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return ~(a | b);
      4'b0110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0000, 4'b0001: return b << sh;
      4'b0010: return b >> sh;
      4'b0011: return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'b1111: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_grant();
    if (m_valid && !resp_ready) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = '0; m_ptr = 0;
  endtask

  // advance one clock, updating the model with the handshake seen before the edge
  task automatic tick();
    int g;
    logic [31:0] r;
    g = exp_grant();
    r = (g < 0) ? 32'd0 : ref_alu(req_op[g*4 +: 4], req_v1[g*32 +: 32], req_v2[g*32 +: 32]);
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1; m_id = g; m_data = r; m_ptr = (g + 1) % N;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*4 +: 4] = op;
    req_v1[i*32 +: 32] = a;
    req_v2[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = '1; resp_ready = 1'b1;
    req_op = '0; req_v1 = '0; req_v2 = '0;
    model_reset();
    #2;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if ({resp_valid, resp_id, resp_data} !== '0) begin n_bad++;
      $display("FAIL reset_resp got v=%b id=%0d d=%h want all 0", resp_valid, resp_id, resp_data); end
    req_valid = '0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    // reset mid-stream
    set_req(0, 4'b1100, 32'd5, 32'd7); req_valid = 4'b0001; resp_ready = 1'b0;
    #1;
    tick();
    n_cmp++; if (resp_valid !== 1'b1 || resp_data !== 32'd12) begin n_bad++;
      $display("FAIL midrst_issue got v=%b d=%0d want v=1 d=12", resp_valid, resp_data); end
    req_valid = '0;
    resetn = 1'b0; model_reset();
    #1;
    n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin n_bad++;
      $display("FAIL midrst_async got v=%b d=%0d want v=0 d=0", resp_valid, resp_data); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale got v=%b want 0", resp_valid); end
    req_valid = 4'b1111; resp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr got %b want 0001", req_ready); end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_single();
    set_req(0, 4'b1110, 32'd10, 32'd3); req_valid = 4'b0001; resp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 32'd7) begin n_bad++;
      $display("FAIL single_resp got v=%b id=%0d d=%0d want v=1 id=0 d=7", resp_valid, resp_id, resp_data); end
    tick();
  endtask

  task automatic test_all_valid();
    int want;
    // previous traffic left the pointer at 1; restart from a reset for a clean 0,1,2,3 order
    resetn = 1'b0; model_reset(); #1;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 4'b1111, 32'hdead0000, 32'(i));
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      want = c % N;
      #1;
      n_cmp++; if (req_ready !== N'(1 << want)) begin n_bad++;
        $display("FAIL allv_grant c=%0d got %b want idx %0d", c, req_ready, want); end
      tick();
      n_cmp++; if (resp_valid !== 1'b1 || int'(resp_id) != want || resp_data !== 32'(want)) begin n_bad++;
        $display("FAIL allv_resp c=%0d got id=%0d d=%0d want %0d", c, resp_id, resp_data, want); end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    set_req(2, 4'b0110, 32'hFFFFFFFF, 32'd1);
    set_req(3, 4'b1100, 32'd100, 32'd23);
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    tick();
    req_valid = 4'b1000; resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL bp_ready c=%0d got %b want 0000", c, req_ready); end
      tick();
      n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 32'd1) begin n_bad++;
        $display("FAIL bp_hold c=%0d got v=%b id=%0d d=%0d want v=1 id=2 d=1", c, resp_valid, resp_id, resp_data); end
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL bp_release got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (resp_id !== 2'd3 || resp_data !== 32'd123) begin n_bad++;
      $display("FAIL bp_next got id=%0d d=%0d want id=3 d=123", resp_id, resp_data); end
    tick();
  endtask

  task automatic test_rr_skip();
    set_req(2, 4'b1111, 32'd0, 32'd22);
    set_req(1, 4'b1111, 32'd0, 32'd11);
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1; tick();               // grant 2 leaves the pointer at 3
    req_valid = 4'b0110;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_first got %b want 0010", req_ready); end
    tick();
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL skip_second got %b want 0100", req_ready); end
    tick();
    n_cmp++; if (resp_id !== 2'd2 || resp_data !== 32'd22) begin n_bad++;
      $display("FAIL skip_resp got id=%0d d=%0d want id=2 d=22", resp_id, resp_data); end
    req_valid = '0;
  endtask

  task automatic test_drain();
    resp_ready = 1'b1; req_valid = '0;
    #1; tick();
    n_cmp++; if (resp_valid !== 1'b0 || resp_data !== 32'd22 || resp_id !== 2'd2) begin n_bad++;
      $display("FAIL drain got v=%b id=%0d d=%0d want v=0 id=2 d=22", resp_valid, resp_id, resp_data); end
  endtask

  task automatic test_random();
    logic [3:0] ops [13] = '{4'b1100, 4'b1110, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0110,
                             4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111, 4'b0101};
    logic [3:0] op;
    logic [31:0] a;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        op = ops[$urandom_range(0, 12)];
        a = (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011}) ? 32'($urandom_range(0, 31)) : $urandom;
        set_req(i, op, a, $urandom);
      end
      req_valid = N'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_cmp++; if (req_ready !== exp_ready()) begin n_bad++;
        $display("FAIL rand_ready c=%0d got %b want %b", c, req_ready, exp_ready()); end
      tick();
      n_cmp++; if (resp_valid !== m_valid || (m_valid && (int'(resp_id) != m_id || resp_data !== m_data))) begin
        n_bad++;
        $display("FAIL rand_resp c=%0d got v=%b id=%0d d=%h want v=%b id=%0d d=%h",
                 c, resp_valid, resp_id, resp_data, m_valid, m_id, m_data);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_rr_skip();
    test_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
